// File: rtl/status_register_unit_if.sv
// Status register unit bus.
//   Purpose : bundles the control inputs and status outputs of status_register_unit.
//   master  : pipeline side; drives stall/flush/update/save/restore/err_clr and observes flags.
//   slave   : status_register_unit; consumes the controls and drives the flag/stack/debug outputs.
//   Signals :
//     freeze, flush, s_bit_exe, cond_pass_exe  update qualifiers
//     alu_flags[3:0]                           {c,n,v,z} from ALU
//     save_req, restore_req, err_clr           LIFO and sticky-error controls
//     status_register[3:0], status_fwd[3:0]    registered / forwarded flags
//     stack_empty, stack_full                  LIFO occupancy
//     ovf_err, unf_err                         sticky LIFO errors
//     update_count[CNT_W-1:0]                  committed ALU flag updates
interface status_register_unit_if #(
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             s_bit_exe;
  logic             cond_pass_exe;
  logic [3:0]       alu_flags;
  logic             save_req;
  logic             restore_req;
  logic             err_clr;
  logic [3:0]       status_register;
  logic [3:0]       status_fwd;
  logic             stack_empty;
  logic             stack_full;
  logic             ovf_err;
  logic             unf_err;
  logic [CNT_W-1:0] update_count;

  modport master (
    output freeze, flush, s_bit_exe, cond_pass_exe, alu_flags,
           save_req, restore_req, err_clr,
    input  status_register, status_fwd, stack_empty, stack_full,
           ovf_err, unf_err, update_count
  );

  modport slave (
    input  freeze, flush, s_bit_exe, cond_pass_exe, alu_flags,
           save_req, restore_req, err_clr,
    output status_register, status_fwd, stack_empty, stack_full,
           ovf_err, unf_err, update_count
  );
endinterface

// File: rtl/status_register_unit.sv
// Status register unit.
//   Purpose : holds the architectural NZCV flags ({c,n,v,z}), captures ALU flags for
//             flag-setting instructions whose condition passed, keeps a small LIFO of
//             saved flag sets for exception entry/return, and exposes sticky LIFO
//             error bits plus a flag-update counter for debug.
//   Ports   : clk  - system clock, posedge
//             rst  - asynchronous active-high reset
//             bus  - status_register_unit_if.slave (controls in, flags/stack/debug out)
//   Config  : STATUS_FWD_EN - when defined, status_fwd bypasses same-cycle pop/update
//             results combinationally; when undefined, status_fwd = status_register.
//   Params  : STACK_DEPTH (>=1) saved-flag entries, CNT_W update counter width.
module status_register_unit #(
  parameter int STACK_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  status_register_unit_if.slave bus
);
  // Pointer must reach STACK_DEPTH itself (the "full" value).
  localparam int PW = (STACK_DEPTH < 1) ? 1 : $clog2(STACK_DEPTH + 1);

  logic [3:0]       status_q, status_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3:0]       stack_q [STACK_DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          empty, full;
  logic          upd, pop, push;
  logic          ovf_set, unf_set;
  logic [PW-1:0] top_idx;
  logic [3:0]    top_flags;

  assign empty = (ptr_q == '0);
  assign full  = (ptr_q == PW'(STACK_DEPTH));

  assign upd  = bus.s_bit_exe & bus.cond_pass_exe & ~bus.flush & ~bus.freeze;
  assign pop  = bus.restore_req & ~empty & ~bus.freeze;
  // A simultaneous restore always wins over save, so save is dropped (no error).
  assign push = bus.save_req & ~full & ~bus.freeze & ~bus.restore_req;

  assign ovf_set = bus.save_req & full & ~bus.freeze & ~bus.restore_req;
  assign unf_set = bus.restore_req & empty & ~bus.freeze;

  assign top_idx = ptr_q - PW'(1);

  // Mux-style read avoids index-width mismatch between ptr and the array range.
  always_comb begin
    top_flags = 4'b0000;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (top_idx == PW'(i)) top_flags = stack_q[i];
  end

  always_comb begin
    status_d = status_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      // Restored flags take precedence; a same-cycle ALU update is discarded.
      status_d = top_flags;
      ptr_d    = ptr_q - PW'(1);
    end else if (upd) begin
      status_d = bus.alu_flags;
      cnt_d    = cnt_q + CNT_W'(1);  // wraps silently
    end
    if (push) ptr_d = ptr_q + PW'(1);
    // err_clr ignores freeze; a new error in the same cycle still sets.
    ovf_d = ovf_set ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (bus.err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'b0000;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 4'b0000;
    end else begin
      status_q <= status_d;
      ptr_q    <= ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      cnt_q    <= cnt_d;
      // Push saves the pre-edge flags, even if an update lands in the same cycle.
      for (int i = 0; i < STACK_DEPTH; i++)
        if (push && ptr_q == PW'(i)) stack_q[i] <= status_q;
    end
  end

  assign bus.status_register = status_q;
  assign bus.stack_empty     = empty;
  assign bus.stack_full      = full;
  assign bus.ovf_err         = ovf_q;
  assign bus.unf_err         = unf_q;
  assign bus.update_count    = cnt_q;

`ifdef STATUS_FWD_EN
  assign bus.status_fwd = pop ? top_flags : (upd ? bus.alu_flags : status_q);
`else
  assign bus.status_fwd = status_q;
`endif

endmodule
